// File: rtl/video_pkg.sv
// Shared raster timing constants and pixel types for the 640x480@60 video path.
package video_pkg;

  typedef logic [9:0]  cnt_t;
  typedef logic [23:0] rgb_t;

  localparam cnt_t H_VISIBLE = 10'd640;
  localparam cnt_t H_FP      = 10'd16;
  localparam cnt_t H_SYNC    = 10'd96;
  localparam cnt_t H_BP      = 10'd48;
  localparam cnt_t H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam cnt_t V_VISIBLE = 10'd480;
  localparam cnt_t V_FP      = 10'd10;
  localparam cnt_t V_SYNC    = 10'd2;
  localparam cnt_t V_BP      = 10'd33;
  localparam cnt_t V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam cnt_t H_SYNC_START = H_VISIBLE + H_FP;
  localparam cnt_t H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam cnt_t V_SYNC_START = V_VISIBLE + V_FP;
  localparam cnt_t V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int unsigned PPU_WIDTH  = 320;
  localparam int unsigned PPU_HEIGHT = 240;

  function automatic logic in_window(input cnt_t pos, input cnt_t lo, input cnt_t hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/hdmi_video_timing_if.sv
// Parallel VGA-style bus from the raster generator to the HDMI transmitter.
interface hdmi_video_timing_if;
  import video_pkg::*;

  logic vga_pclk;
  logic vga_de;
  logic vga_hs;
  logic vga_vs;
  rgb_t vga_rgb;

  modport master (output vga_pclk, output vga_de, output vga_hs, output vga_vs, output vga_rgb);
  modport slave  (input  vga_pclk, input  vga_de, input  vga_hs, input  vga_vs, input  vga_rgb);

endinterface

// File: rtl/hdmi_video_timing_sync_counter.sv
// Raster position counters and the stage-0 de/hsync/vsync decode.
module video_sync_counter
  import video_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  output cnt_t hcount,
  output cnt_t vcount,
  output logic de,
  output logic hs,
  output logic vs
);

  cnt_t hcount_r;
  cnt_t vcount_r;

  // Raster position; the line counter advances on the last pixel of each line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_r <= 10'd0;
      vcount_r <= 10'd0;
    end else begin
      if (hcount_r == H_TOTAL - 10'd1) begin
        hcount_r <= 10'd0;
        if (vcount_r == V_TOTAL - 10'd1) begin
          vcount_r <= 10'd0;
        end else begin
          vcount_r <= vcount_r + 10'd1;
        end
      end else begin
        hcount_r <= hcount_r + 10'd1;
      end
    end
  end

  // Stage-0 timing decode, syncs are active-low.
  always_comb begin
    de = (hcount_r < H_VISIBLE) && (vcount_r < V_VISIBLE);
    hs = !in_window(hcount_r, H_SYNC_START, H_SYNC_END);
    vs = !in_window(vcount_r, V_SYNC_START, V_SYNC_END);
  end

  assign hcount = hcount_r;
  assign vcount = vcount_r;

endmodule

// File: rtl/hdmi_video_timing.sv
// 640x480 raster generator with 2x2 pixel doubling of the PPU's 320x240 row buffer,
// a three-stage RAM/palette pipeline and PPU pacing strobes.
module hdmi_video_timing
  import video_pkg::*;
(
  input  logic                 video_clk,
  input  logic                 rst_n,
  hdmi_video_timing_if.master  vga,
  output logic [8:0]           rowram_rdaddr,
  input  logic [9:0]           rowram_rddata,
  output logic [9:0]           color_rdaddr,
  input  rgb_t                 color_rddata,
  output logic                 rowram_swap,
  output logic                 vblank_start,
  output logic                 vblank_end_soon,
  output logic [7:0]           next_row
);

  cnt_t       hcount_s;
  cnt_t       vcount_s;
  logic       de_s;
  logic       hs_s;
  logic       vs_s;
  logic       swap_s;
  logic       vbs_s;
  logic       vbe_s;
  logic [7:0] next_row_s;

  logic [1:0] de_pipe_r;
  logic [1:0] hs_pipe_r;
  logic [1:0] vs_pipe_r;
  logic       vga_de_r;
  logic       vga_hs_r;
  logic       vga_vs_r;
  rgb_t       vga_rgb_r;
  logic       swap_r;
  logic       vbs_r;
  logic       vbe_r;
  logic [7:0] next_row_r;

  video_sync_counter u_sync (
    .clk    (video_clk),
    .rst_n  (rst_n),
    .hcount (hcount_s),
    .vcount (vcount_s),
    .de     (de_s),
    .hs     (hs_s),
    .vs     (vs_s)
  );

  // Stage-0 row RAM address and next-cycle strobe values.
  always_comb begin
    if (hcount_s < H_VISIBLE) begin
      rowram_rdaddr = hcount_s[9:1];
    end else begin
      rowram_rdaddr = 9'd0;
    end
    // Swap on the last pixel of the odd line of each doubled pair, plus before line 0.
    swap_s = (hcount_s == H_TOTAL - 10'd1) &&
             ((vcount_s[0] && (vcount_s < V_VISIBLE - 10'd1)) || (vcount_s == V_TOTAL - 10'd1));
    vbs_s  = (hcount_s == 10'd0) && (vcount_s == V_VISIBLE);
    vbe_s  = (hcount_s == 10'd0) && (vcount_s == V_TOTAL - 10'd2);
    if (vcount_s < V_VISIBLE - 10'd2) begin
      next_row_s = vcount_s[8:1] + 8'd1;
    end else begin
      next_row_s = 8'd0;
    end
  end

  assign color_rdaddr = rowram_rddata;

  // Delay de/hs/vs to line up with the palette output and register the pins.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      de_pipe_r <= 2'b00;
      hs_pipe_r <= 2'b11;
      vs_pipe_r <= 2'b11;
      vga_de_r  <= 1'b0;
      vga_hs_r  <= 1'b1;
      vga_vs_r  <= 1'b1;
      vga_rgb_r <= 24'h000000;
    end else begin
      de_pipe_r <= {de_pipe_r[0], de_s};
      hs_pipe_r <= {hs_pipe_r[0], hs_s};
      vs_pipe_r <= {vs_pipe_r[0], vs_s};
      vga_de_r  <= de_pipe_r[1];
      vga_hs_r  <= hs_pipe_r[1];
      vga_vs_r  <= vs_pipe_r[1];
      vga_rgb_r <= de_pipe_r[1] ? color_rddata : 24'h000000;
    end
  end

  // PPU pacing strobes and next-row index.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      swap_r     <= 1'b0;
      vbs_r      <= 1'b0;
      vbe_r      <= 1'b0;
      next_row_r <= 8'd0;
    end else begin
      swap_r     <= swap_s;
      vbs_r      <= vbs_s;
      vbe_r      <= vbe_s;
      next_row_r <= next_row_s;
    end
  end

  assign vga.vga_pclk    = ~video_clk;
  assign vga.vga_de      = vga_de_r;
  assign vga.vga_hs      = vga_hs_r;
  assign vga.vga_vs      = vga_vs_r;
  assign vga.vga_rgb     = vga_rgb_r;
  assign rowram_swap     = swap_r;
  assign vblank_start    = vbs_r;
  assign vblank_end_soon = vbe_r;
  assign next_row        = next_row_r;

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Randomized bench: RAM models plus a cycle-indexed reference of the raster rules.
module tb_hdmi_video_timing;
  import video_pkg::*;

  logic       video_clk = 1'b0;
  logic       rst_n     = 1'b0;
  logic [8:0] rowram_rdaddr;
  logic [9:0] rowram_rddata;
  logic [9:0] color_rdaddr;
  rgb_t       color_rddata;
  logic       rowram_swap;
  logic       vblank_start;
  logic       vblank_end_soon;
  logic [7:0] next_row;

  hdmi_video_timing_if vga_bus();

  hdmi_video_timing dut (
    .video_clk       (video_clk),
    .rst_n           (rst_n),
    .vga             (vga_bus),
    .rowram_rdaddr   (rowram_rdaddr),
    .rowram_rddata   (rowram_rddata),
    .color_rdaddr    (color_rdaddr),
    .color_rddata    (color_rddata),
    .rowram_swap     (rowram_swap),
    .vblank_start    (vblank_start),
    .vblank_end_soon (vblank_end_soon),
    .next_row        (next_row)
  );

  always #20 video_clk = ~video_clk;

  logic [9:0] row_mem [320];
  rgb_t       pal_mem [1024];

  // Synchronous-read RAM models, one cycle of latency each.
  always @(posedge video_clk) begin
    rowram_rddata <= row_mem[rowram_rdaddr];
    color_rddata  <= pal_mem[color_rdaddr];
  end

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic fill_mem(input bit randomize_data);
    for (int i = 0; i < 320; i++) begin
      row_mem[i] = randomize_data ? 10'($urandom) : 10'(i);
    end
    for (int i = 0; i < 1024; i++) begin
      pal_mem[i] = randomize_data ? 24'($urandom) : 24'(i);
    end
  endtask

  // Expected pin vector n clocks after reset release, sampled while the clock is low.
  // Layout: {pclk, de, hs, vs, swap, vblank_start, vblank_end_soon, next_row, rgb, rdaddr}.
  function automatic logic [47:0] expected(input int n);
    int         h, v, m, nxt;
    logic       de, hs, vs, sw, vbs, vbe;
    logic [7:0] nr;
    rgb_t       rgb;
    logic [8:0] ra;
    h  = n % 800;
    ra = (h < 640) ? 9'(h / 2) : 9'd0;
    de = 1'b0; hs = 1'b1; vs = 1'b1; rgb = 24'h0;
    if (n >= 3) begin
      m   = n - 3;
      h   = m % 800;
      v   = (m / 800) % 525;
      de  = (h < 640) && (v < 480);
      hs  = !(h >= 656 && h < 752);
      vs  = !(v >= 490 && v < 492);
      rgb = de ? pal_mem[row_mem[h / 2]] : 24'h0;
    end
    sw = 1'b0; vbs = 1'b0; vbe = 1'b0; nr = 8'd0;
    if (n >= 1) begin
      m   = n - 1;
      h   = m % 800;
      v   = (m / 800) % 525;
      nxt = (v + 1) % 525;
      sw  = (h == 799) && (nxt % 2 == 0) && (nxt < 480);
      vbs = (h == 0) && (v == 480);
      vbe = (h == 0) && (v == 523);
      nr  = (v < 480) ? 8'(((v / 2) + 1) % 240) : 8'd0;
    end
    return {1'b1, de, hs, vs, sw, vbs, vbe, nr, rgb, ra};
  endfunction

  function automatic logic [47:0] observed();
    return {vga_bus.vga_pclk, vga_bus.vga_de, vga_bus.vga_hs, vga_bus.vga_vs,
            rowram_swap, vblank_start, vblank_end_soon, next_row, vga_bus.vga_rgb, rowram_rdaddr};
  endfunction

  localparam logic [47:0] RESET_VEC = {1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 8'd0, 24'h0, 9'd0};

  // Release reset, compare every cycle against the reference, then reset mid-line.
  task automatic run_phase(input int cycles, input bit randomize_data);
    int n;
    fill_mem(randomize_data);
    @(negedge video_clk);
    rst_n = 1'b1;
    n = 0;
    repeat (cycles) begin
      #1;
      check_eq($sformatf("cycle%0d", n), 64'(observed()), 64'(expected(n)));
      @(negedge video_clk);
      n++;
    end
    @(posedge video_clk);
    #1;
    check_eq("pclk_high_phase", 64'(vga_bus.vga_pclk), 64'(1'b0));
    @(negedge video_clk);
    #5;
    rst_n = 1'b0;
    #1;
    check_eq("async_reset_values", 64'(observed()), 64'(RESET_VEC));
    repeat (3) @(negedge video_clk);
    check_eq("reset_held_values", 64'(observed()), 64'(RESET_VEC));
  endtask

  initial begin
    fill_mem(1'b0);
    repeat (3) @(negedge video_clk);
    #1;
    check_eq("power_on_reset", 64'(observed()), 64'(RESET_VEC));
    run_phase(16000 + int'($urandom_range(0, 799)), 1'b0);
    run_phase(30000 + int'($urandom_range(0, 799)), 1'b1);
    run_phase(9000 + int'($urandom_range(0, 799)), 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
